// File: rtl/bus_master_if.sv
// Master-side agent for the shared bus: queues local commands, requests the bus and issues single-cycle beats.
// Optional BUS_MASTER_HOLD_LIMIT_EN caps consecutive beats per request at HOLD_MAX, followed by a one-cycle yield.
module bus_master_if #(
   parameter int AW       = 8,
   parameter int DW       = 32,
   parameter int DEPTH    = 4,
   parameter int HOLD_MAX = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          bus_req,
   input  logic          bus_grant,
   output logic          bus_en,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   output logic          idle,
   output logic [1:0]    o_dbg_state
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int HCW = $clog2(HOLD_MAX + 1);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (HOLD_MAX < 1)) begin : g_bad_param
      $error("bus_master_if: DEPTH must be a power of two >= 2 and HOLD_MAX >= 1");
   end

`ifdef BUS_MASTER_HOLD_LIMIT_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_YIELD = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1} state_t;
`endif

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count, w_count_nxt;
   logic          r_mem_we    [DEPTH];
   logic [AW-1:0] r_mem_addr  [DEPTH];
   logic [DW-1:0] r_mem_wdata [DEPTH];
   logic          w_full, w_empty, w_push, w_beat;
   logic          r_rd_pend, r_rsp_valid;
   logic [DW-1:0] r_rsp_rdata;
   logic          w_hold_hit;

   assign w_full      = (r_count == CW'(DEPTH));
   assign w_empty     = (r_count == '0);
   // Gating with reset_n keeps the handshake and idle at 0 while reset is held.
   assign cmd_ready   = reset_n && !w_full;
   assign w_push      = cmd_valid && cmd_ready;
   assign bus_req     = (r_state == ST_ACTIVE);
   assign w_beat      = bus_req && bus_grant && !w_empty;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_beat);

   assign bus_en      = w_beat;
   assign bus_we      = w_beat && r_mem_we[r_rd_ptr];
   assign bus_addr    = w_beat ? r_mem_addr[r_rd_ptr]  : '0;
   assign bus_wdata   = w_beat ? r_mem_wdata[r_rd_ptr] : '0;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign idle        = reset_n && w_empty && (r_state == ST_IDLE) && !r_rd_pend;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_we[r_wr_ptr]    <= cmd_we;
         r_mem_addr[r_wr_ptr]  <= cmd_addr;
         r_mem_wdata[r_wr_ptr] <= cmd_wdata;
      end
   end

`ifdef BUS_MASTER_HOLD_LIMIT_EN
   logic [HCW-1:0] r_beat_cnt;

   assign w_hold_hit = w_beat && ((r_beat_cnt + HCW'(1)) == HCW'(HOLD_MAX));

   always_ff @(posedge clk) begin
      if (!reset_n || (r_state != ST_ACTIVE)) r_beat_cnt <= '0;
      else if (w_beat)                        r_beat_cnt <= r_beat_cnt + HCW'(1);
   end
`else
   assign w_hold_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_rd_pend   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_beat) r_rd_ptr <= r_rd_ptr + PW'(1);
         // Slave data arrives the cycle after a read beat; it is registered then presented.
         r_rd_pend   <= w_beat && !r_mem_we[r_rd_ptr];
         r_rsp_valid <= r_rd_pend;
         r_rsp_rdata <= r_rd_pend ? bus_rdata : '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_count_nxt != '0) w_state_nxt = ST_ACTIVE;
         ST_ACTIVE: begin
            if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
`ifdef BUS_MASTER_HOLD_LIMIT_EN
            else if (w_hold_hit)   w_state_nxt = ST_YIELD;
`endif
         end
`ifdef BUS_MASTER_HOLD_LIMIT_EN
         ST_YIELD:  w_state_nxt = (w_count_nxt != '0) ? ST_ACTIVE : ST_IDLE;
`endif
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: table of per-cycle vectors, a beat-order scoreboard and a hand-written reset sequence.
module tb_bus_master_if;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int W  = 1 + AW + DW;

   logic          clk = 1'b0;
   logic          reset_n, cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          bus_req, bus_grant, bus_en, bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata, bus_rdata;
   logic          idle;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];

   bus_master_if #(.AW(AW), .DW(DW), .DEPTH(4), .HOLD_MAX(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .bus_req(bus_req), .bus_grant(bus_grant), .bus_en(bus_en), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .idle(idle), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         nm;
      logic          rst_n, v, we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic          g;
      logic [DW-1:0] rd;
      logic          e_rdy, e_rv;
      logic [DW-1:0] e_rdat;
      logic          e_req, e_en, e_we;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_wd;
      logic          e_idle, idle_care;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic rst_n, v, we, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic g, input logic [DW-1:0] rd,
                               input logic e_rdy, e_rv, input logic [DW-1:0] e_rdat,
                               input logic e_req, e_en, e_we, input logic [AW-1:0] e_a,
                               input logic [DW-1:0] e_wd, input logic e_idle, idle_care);
      vec_t t;
      t.nm = nm; t.rst_n = rst_n; t.v = v; t.we = we; t.a = a; t.wd = wd; t.g = g; t.rd = rd;
      t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_rdat = e_rdat; t.e_req = e_req; t.e_en = e_en;
      t.e_we = e_we; t.e_a = e_a; t.e_wd = e_wd; t.e_idle = e_idle; t.idle_care = idle_care;
      return t;
   endfunction

   task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s %s: got %0h expected %0h", nm, fld, act, exp);
      end
   endtask

   task automatic drive(input logic rst_n, v, we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic g, input logic [DW-1:0] rd);
      @(posedge clk);
      #1;
      reset_n = rst_n; cmd_valid = v; cmd_we = we; cmd_addr = a; cmd_wdata = wd;
      bus_grant = g; bus_rdata = rd;
   endtask

   // Every beat must match the oldest accepted command.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus_en === 1'b1) begin
         if (exp_q.size() == 0) chk("sb", "extra_beat", 64'(bus_addr), 64'hFFFF);
         else chk("sb", "beat", 64'({bus_we, bus_addr, bus_wdata}), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      bus_grant = 1'b0; bus_rdata = '0;
      @(posedge clk);

      for (int i = 0; i < 3; i++)
         vecs.push_back(mk("rst", 0,1,1,8'h55,32'hAAAA5555,1,0, 0,0,0,0,0,0,0,0,0,1));
      vecs.push_back(mk("rel1", 1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("rel2", 1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("wr0", 1,1,1,8'h10,32'h12345678,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("wr1", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h10,32'h12345678,0,1));
      vecs.push_back(mk("wr2", 1,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("st0", 1,1,1,8'h20,32'hCAFEF00D,0,0, 1,0,0,0,0,0,0,0,1,1));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk("st_wait", 1,0,0,0,0,0,0, 1,0,0,1,0,0,0,0,0,1));
      vecs.push_back(mk("st4", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h20,32'hCAFEF00D,0,1));
      vecs.push_back(mk("st5", 1,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("rd0", 1,1,0,8'h30,0,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("rd1", 1,0,0,0,0,1,0, 1,0,0,1,1,0,8'h30,0,0,1));
      vecs.push_back(mk("rd2", 1,0,0,0,0,1,32'hDEADBEEF, 1,0,0,0,0,0,0,0,0,1));
      vecs.push_back(mk("rd3", 1,0,0,0,0,1,0, 1,1,32'hDEADBEEF,0,0,0,0,0,0,0));
      vecs.push_back(mk("rd4", 1,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("f0", 1,1,1,8'h41,32'h10000001,0,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("f1", 1,1,1,8'h42,32'h10000002,0,0, 1,0,0,1,0,0,0,0,0,1));
      vecs.push_back(mk("f2", 1,1,1,8'h43,32'h10000003,0,0, 1,0,0,1,0,0,0,0,0,1));
      vecs.push_back(mk("f3", 1,1,1,8'h44,32'h10000004,0,0, 1,0,0,1,0,0,0,0,0,1));
      vecs.push_back(mk("f4_full", 1,1,1,8'h45,32'h10000005,0,0, 0,0,0,1,0,0,0,0,0,1));
      vecs.push_back(mk("f5", 1,0,0,0,0,1,0, 0,0,0,1,1,1,8'h41,32'h10000001,0,1));
      vecs.push_back(mk("f6", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h42,32'h10000002,0,1));
      vecs.push_back(mk("f7_preempt", 1,0,0,0,0,0,0, 1,0,0,1,0,0,0,0,0,1));
      vecs.push_back(mk("f8", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h43,32'h10000003,0,1));
      vecs.push_back(mk("f9", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h44,32'h10000004,0,1));
      vecs.push_back(mk("f10", 1,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("b0", 1,1,1,8'h50,32'h50505050,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("b1_pushpop", 1,1,1,8'h51,32'h51515151,1,0, 1,0,0,1,1,1,8'h50,32'h50505050,0,1));
      vecs.push_back(mk("b2", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h51,32'h51515151,0,1));
      vecs.push_back(mk("b3", 1,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("r0", 1,1,0,8'h60,0,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("r1", 1,1,0,8'h61,0,1,0, 1,0,0,1,1,0,8'h60,0,0,1));
      vecs.push_back(mk("r2", 1,0,0,0,0,1,32'h60600001, 1,0,0,1,1,0,8'h61,0,0,1));
      vecs.push_back(mk("r3", 1,0,0,0,0,1,32'h61610002, 1,1,32'h60600001,0,0,0,0,0,0,1));
      vecs.push_back(mk("r4", 1,0,0,0,0,1,0, 1,1,32'h61610002,0,0,0,0,0,0,0));
      vecs.push_back(mk("r5", 1,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("h0", 1,1,1,8'h71,32'h70000001,0,0, 1,0,0,0,0,0,0,0,1,1));
      vecs.push_back(mk("h1", 1,1,1,8'h72,32'h70000002,0,0, 1,0,0,1,0,0,0,0,0,1));
      vecs.push_back(mk("h2", 1,1,1,8'h73,32'h70000003,0,0, 1,0,0,1,0,0,0,0,0,1));
      vecs.push_back(mk("h3", 1,1,1,8'h74,32'h70000004,0,0, 1,0,0,1,0,0,0,0,0,1));
      vecs.push_back(mk("h4", 1,0,0,0,0,1,0, 0,0,0,1,1,1,8'h71,32'h70000001,0,1));
      vecs.push_back(mk("h5", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h72,32'h70000002,0,1));
`ifdef BUS_MASTER_HOLD_LIMIT_EN
      vecs.push_back(mk("h6_yield", 1,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,0,1));
      vecs.push_back(mk("h7", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h73,32'h70000003,0,1));
      vecs.push_back(mk("h8", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h74,32'h70000004,0,1));
`else
      vecs.push_back(mk("h6", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h73,32'h70000003,0,1));
      vecs.push_back(mk("h7", 1,0,0,0,0,1,0, 1,0,0,1,1,1,8'h74,32'h70000004,0,1));
      vecs.push_back(mk("h8", 1,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,1,1));
`endif
      vecs.push_back(mk("h9", 1,0,0,0,0,1,0, 1,0,0,0,0,0,0,0,1,1));

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].g, vecs[i].rd);
         if (vecs[i].rst_n && vecs[i].v && vecs[i].e_rdy)
            exp_q.push_back({vecs[i].we, vecs[i].a, vecs[i].wd});
         @(negedge clk);
         chk(vecs[i].nm, "cmd_ready", 64'(cmd_ready), 64'(vecs[i].e_rdy));
         chk(vecs[i].nm, "rsp_valid", 64'(rsp_valid), 64'(vecs[i].e_rv));
         if (vecs[i].e_rv || !vecs[i].rst_n)
            chk(vecs[i].nm, "rsp_rdata", 64'(rsp_rdata), 64'(vecs[i].e_rdat));
         chk(vecs[i].nm, "bus_req", 64'(bus_req), 64'(vecs[i].e_req));
         chk(vecs[i].nm, "bus_en", 64'(bus_en), 64'(vecs[i].e_en));
         chk(vecs[i].nm, "bus_we", 64'(bus_we), 64'(vecs[i].e_we));
         chk(vecs[i].nm, "bus_addr", 64'(bus_addr), 64'(vecs[i].e_a));
         chk(vecs[i].nm, "bus_wdata", 64'(bus_wdata), 64'(vecs[i].e_wd));
         if (vecs[i].idle_care)
            chk(vecs[i].nm, "idle", 64'(idle), 64'(vecs[i].e_idle));
      end

      // Reset while a write is queued and a read response is in flight.
      drive(1, 1, 0, 8'h80, 32'h0, 1, 32'h0);
      exp_q.push_back({1'b0, 8'h80, 32'h0});
      drive(1, 1, 1, 8'h81, 32'h81818181, 1, 32'h0);
      exp_q.push_back({1'b1, 8'h81, 32'h81818181});
      drive(0, 0, 0, 8'h0, 32'h0, 1, 32'h11111111);
      @(negedge clk);
      chk("mid_rst", "cmd_ready", 64'(cmd_ready), 64'h0);
      chk("mid_rst", "idle", 64'(idle), 64'h0);
      drive(1, 0, 0, 8'h0, 32'h0, 1, 32'h22222222);
      exp_q.delete();
      @(negedge clk);
      chk("post_rst1", "bus_req", 64'(bus_req), 64'h0);
      chk("post_rst1", "bus_en", 64'(bus_en), 64'h0);
      chk("post_rst1", "rsp_valid", 64'(rsp_valid), 64'h0);
      chk("post_rst1", "cmd_ready", 64'(cmd_ready), 64'h1);
      chk("post_rst1", "idle", 64'(idle), 64'h1);
      drive(1, 0, 0, 8'h0, 32'h0, 1, 32'h0);
      @(negedge clk);
      chk("post_rst2", "bus_req", 64'(bus_req), 64'h0);
      chk("post_rst2", "rsp_valid", 64'(rsp_valid), 64'h0);
      chk("post_rst2", "idle", 64'(idle), 64'h1);

      chk("end", "sb_leftover", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
